sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Parametrised simulation run controller placed between the bench clock/reset generator and riscv_top.
- Synchronises an external async active-low reset and holds the core in reset for a programmable number of cycles.
- Releases multiple reset channels in a staggered sequence, then asserts rdy.
- Counts run cycles and terminates on a halt request or a cycle limit, reporting done/timeout.

Parameters:
- N_OUT, 2, number of reset output channels, minimum 1.
- HOLD_CYCLES, 25, cycles of reset hold after the synchronised release, minimum 1.
- STAGGER, 4, cycles between successive channel releases, minimum 1.
- MAX_CYCLES, 0, run-cycle limit; 0 means unlimited.
- CNT_W, 32, cycle counter width.

Ports:
- clk  in  1  bench clock.
- rst_n  in  1  asynchronous active-low reset.
- halt_in  in  1  core halt request, level, sampled only in RUN.
- pause_in  in  1  freezes cycle_cnt while high in RUN.
- restart_in  in  1  synchronous restart request, any state.
- core_rst_n  out  N_OUT  per-channel active-low reset to the design.
- rdy  out  1  core-ready/enable.
- cycle_cnt  out  CNT_W  run cycles elapsed.
- done  out  1  sticky run-finished flag.
- timeout  out  1  sticky; set when done was caused by the cycle limit.
- state  out  2  HOLD=0, RELEASE=1, RUN=2, DONE=3.

Behaviour:
- All outputs are registered.
- rst_n low, asynchronous:
  - core_rst_n = all 0, rdy = 0, cycle_cnt = 0, done = 0, timeout = 0, state = HOLD.
  - Hold counter = 0; 2-flop sync chain = 0.
- rst_n rise: deassertion passes through a 2-flop synchroniser. The internal sync_n goes high at the 2nd rising edge after the rise.
- HOLD:
  - The hold counter increments each cycle while sync_n is high.
  - On the edge where the counter equals HOLD_CYCLES-1: go to RELEASE, set core_rst_n[0] = 1, clear the stagger counter.
  - core_rst_n[0] therefore rises at edge 2+HOLD_CYCLES after the rst_n rise.
- RELEASE:
  - The stagger counter increments each cycle.
  - core_rst_n[i] rises STAGGER*i edges after core_rst_n[0]. Once released, a channel stays high until reset or restart.
  - One edge after the last channel rises: rdy = 1, state = RUN.
  - N_OUT = 1: rdy rises one edge after core_rst_n[0].
- RUN:
  - cycle_cnt increments on every edge with pause_in = 0, and saturates at all-ones.
  - halt_in = 1 sampled at an edge: state = DONE, done = 1, rdy = 0, cycle_cnt not incremented that edge.
  - Limit: when MAX_CYCLES ≠ 0 and an increment would make cycle_cnt == MAX_CYCLES, the increment is performed and state = DONE, done = 1, timeout = 1, rdy = 0.
  - halt_in and limit on the same edge: halt wins, so timeout = 0 and cycle_cnt is not incremented.
  - pause_in = 1 blocks the limit check (no increment means no limit hit). Halt is still honoured.
- DONE:
  - done and timeout are sticky; cycle_cnt is frozen; rdy = 0; core_rst_n is unchanged (all high).
  - halt_in and pause_in are ignored.
- restart_in = 1 at an edge in any state:
  - core_rst_n = 0, rdy = 0, cycle_cnt = 0, done = 0, timeout = 0, hold counter = 0, state = HOLD.
  - The sync chain is not cleared, so HOLD counting restarts on the next edge.
  - restart_in has priority over all other inputs.
- rst_n low mid-RUN or mid-RELEASE: immediate full reset as above. No channel may glitch high during or after the assert.
- The counter and state encoding contain no X after reset.
- state values 0–3 only.

Test Plan:
- Defaults, rst_n low for 10 edges then high → core_rst_n[0] rises at edge 27 after the rst_n rise, core_rst_n[1] at 31, rdy at 32, cycle_cnt = 1 at edge 33.
- RUN 100 edges, then halt_in = 1 for one cycle → state = DONE, done = 1, timeout = 0, rdy = 0. cycle_cnt = 100 and stays 100 over 50 further edges.
- MAX_CYCLES = 20, halt_in = 0 → cycle_cnt reaches 20 exactly, done = 1, timeout = 1, rdy = 0. Repeat with halt_in high on the limit edge → cycle_cnt = 19, timeout = 0.
- RUN with pause_in high for 7 of 30 edges → cycle_cnt = 23. halt_in during pause still gives done = 1.
- In DONE, restart_in pulse → all core_rst_n = 0 and counters cleared next edge. Release sequence repeats without the 2-edge sync delay (core_rst_n[0] high 25 edges later).
- rst_n dropped mid-RELEASE (after core_rst_n[0] high, before core_rst_n[1]) → all outputs reset asynchronously, before the next edge. A full sequence replays after release. N_OUT = 1 and CNT_W = 4 saturation at 15 are checked in separate builds.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: synchronises the bench reset, releases staggered
// core resets, then counts run cycles until a halt request or cycle limit.
module sim_run_ctrl #(
    parameter int N_OUT       = 2,
    parameter int HOLD_CYCLES = 25,
    parameter int STAGGER     = 4,
    parameter int MAX_CYCLES  = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_in,
    input  logic             pause_in,
    input  logic             restart_in,
    output logic [N_OUT-1:0] core_rst_n,
    output logic             rdy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             timeout,
    output logic [1:0]       state
);

    localparam int REL_LAST = STAGGER * (N_OUT - 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;
    localparam logic [HW-1:0]    HOLD_END = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]    REL_END  = SW'(REL_LAST);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);
    localparam bit               LIM_EN   = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               sync_n;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      stg_q, stg_d;
    logic [N_OUT-1:0]   core_q, core_d;
    logic               rdy_q, rdy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               to_q, to_d;

    // Cycle counter sticks at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign sync_n = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stg_q   <= '0;
            core_q  <= '0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            core_q  <= core_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        core_d  = core_q;
        rdy_d   = rdy_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        to_d    = to_q;

        if (restart_in) begin
            // Sync chain is left alone, so HOLD counting resumes immediately.
            state_d = ST_HOLD;
            hold_d  = '0;
            stg_d   = '0;
            core_d  = '0;
            rdy_d   = 1'b0;
            cnt_d   = '0;
            done_d  = 1'b0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (sync_n) begin
                        if (hold_q == HOLD_END) begin
                            state_d   = ST_RELEASE;
                            core_d[0] = 1'b1;
                            stg_d     = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    stg_d = stg_q + 1'b1;
                    for (int i = 1; i < N_OUT; i++) begin
                        if (stg_q == SW'(STAGGER * i - 1)) begin
                            core_d[i] = 1'b1;
                        end
                    end
                    if (stg_q == REL_END) begin
                        state_d = ST_RUN;
                        rdy_d   = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Halt outranks both pause and the cycle limit.
                    if (halt_in) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        rdy_d   = 1'b0;
                    end else if (!pause_in) begin
                        cnt_d = sat_inc(cnt_q);
                        if (LIM_EN && !(&cnt_q) && (cnt_q == LIMIT_M1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            to_d    = 1'b1;
                            rdy_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    rdy_d = 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n = core_q;
    assign rdy        = rdy_q;
    assign cycle_cnt  = cnt_q;
    assign done       = done_q;
    assign timeout    = to_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: default build, a cycle-limited build and a
// single-channel narrow-counter build share one clock.
module tb_sim_run_ctrl;

    logic clk;
    int   vectors;
    int   miscompares;

    // default build
    logic        rst0_n, halt0, pause0, restart0;
    logic [1:0]  core0;
    logic        rdy0, done0, to0;
    logic [31:0] cnt0;
    logic [1:0]  st0;

    // MAX_CYCLES = 20 build
    logic        rst1_n, halt1, pause1, restart1;
    logic [1:0]  core1;
    logic        rdy1, done1, to1;
    logic [31:0] cnt1;
    logic [1:0]  st1;

    // N_OUT = 1, CNT_W = 4 build
    logic        rst2_n, halt2, pause2, restart2;
    logic [0:0]  core2;
    logic        rdy2, done2, to2;
    logic [3:0]  cnt2;
    logic [1:0]  st2;

    sim_run_ctrl u0 (
        .clk(clk), .rst_n(rst0_n), .halt_in(halt0), .pause_in(pause0),
        .restart_in(restart0), .core_rst_n(core0), .rdy(rdy0),
        .cycle_cnt(cnt0), .done(done0), .timeout(to0), .state(st0)
    );

    sim_run_ctrl #(.MAX_CYCLES(20)) u1 (
        .clk(clk), .rst_n(rst1_n), .halt_in(halt1), .pause_in(pause1),
        .restart_in(restart1), .core_rst_n(core1), .rdy(rdy1),
        .cycle_cnt(cnt1), .done(done1), .timeout(to1), .state(st1)
    );

    sim_run_ctrl #(.N_OUT(1), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst2_n), .halt_in(halt2), .pause_in(pause2),
        .restart_in(restart2), .core_rst_n(core2), .rdy(rdy2),
        .cycle_cnt(cnt2), .done(done2), .timeout(to2), .state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (10) tick();
        vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL rst_core got=%b exp=00", core0); end
        vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy got=%b exp=0", rdy0); end
        vectors++; if (cnt0 !== 32'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
        vectors++; if (done0 !== 1'b0 || to0 !== 1'b0) begin miscompares++; $display("FAIL rst_flags got=%b%b exp=00", done0, to0); end
        vectors++; if (st0 !== 2'd0) begin miscompares++; $display("FAIL rst_state got=%0d exp=0", st0); end
    endtask

    // rst0_n rises just after an edge; edge k is the k-th rising edge after that
    task automatic test_release_seq();
        rst0_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 26) begin
                vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL rel_e26 got=%b exp=00", core0); end
            end
            if (k == 27) begin
                vectors++; if (core0 !== 2'b01) begin miscompares++; $display("FAIL rel_e27 got=%b exp=01", core0); end
                vectors++; if (st0 !== 2'd1) begin miscompares++; $display("FAIL rel_e27_state got=%0d exp=1", st0); end
            end
            if (k == 30) begin
                vectors++; if (core0 !== 2'b01) begin miscompares++; $display("FAIL rel_e30 got=%b exp=01", core0); end
            end
            if (k == 31) begin
                vectors++; if (core0 !== 2'b11) begin miscompares++; $display("FAIL rel_e31 got=%b exp=11", core0); end
                vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL rel_e31_rdy got=%b exp=0", rdy0); end
            end
            if (k == 32) begin
                vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL rel_e32_rdy got=%b exp=1", rdy0); end
                vectors++; if (st0 !== 2'd2) begin miscompares++; $display("FAIL rel_e32_state got=%0d exp=2", st0); end
                vectors++; if (cnt0 !== 32'd0) begin miscompares++; $display("FAIL rel_e32_cnt got=%0d exp=0", cnt0); end
            end
            if (k == 33) begin
                vectors++; if (cnt0 !== 32'd1) begin miscompares++; $display("FAIL rel_e33_cnt got=%0d exp=1", cnt0); end
            end
        end
    endtask

    task automatic test_halt();
        repeat (99) tick();
        vectors++; if (cnt0 !== 32'd100) begin miscompares++; $display("FAIL halt_pre_cnt got=%0d exp=100", cnt0); end
        halt0 = 1'b1;
        tick();
        halt0 = 1'b0;
        vectors++; if (st0 !== 2'd3) begin miscompares++; $display("FAIL halt_state got=%0d exp=3", st0); end
        vectors++; if (done0 !== 1'b1 || to0 !== 1'b0) begin miscompares++; $display("FAIL halt_flags got=%b%b exp=10", done0, to0); end
        vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL halt_rdy got=%b exp=0", rdy0); end
        vectors++; if (cnt0 !== 32'd100) begin miscompares++; $display("FAIL halt_cnt got=%0d exp=100", cnt0); end
        repeat (50) tick();
        vectors++; if (cnt0 !== 32'd100) begin miscompares++; $display("FAIL halt_frozen_cnt got=%0d exp=100", cnt0); end
        vectors++; if (done0 !== 1'b1 || st0 !== 2'd3) begin miscompares++; $display("FAIL halt_sticky got done=%b st=%0d exp done=1 st=3", done0, st0); end
        vectors++; if (core0 !== 2'b11) begin miscompares++; $display("FAIL halt_core got=%b exp=11", core0); end
    endtask

    task automatic test_restart();
        restart0 = 1'b1;
        tick();
        restart0 = 1'b0;
        vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL rs_core got=%b exp=00", core0); end
        vectors++; if (cnt0 !== 32'd0 || done0 !== 1'b0) begin miscompares++; $display("FAIL rs_clear got cnt=%0d done=%b exp cnt=0 done=0", cnt0, done0); end
        vectors++; if (st0 !== 2'd0 || rdy0 !== 1'b0) begin miscompares++; $display("FAIL rs_state got st=%0d rdy=%b exp st=0 rdy=0", st0, rdy0); end
        repeat (24) tick();
        vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL rs_e24 got=%b exp=00", core0); end
        tick();
        vectors++; if (core0 !== 2'b01 || st0 !== 2'd1) begin miscompares++; $display("FAIL rs_e25 got core=%b st=%0d exp core=01 st=1", core0, st0); end
        repeat (4) tick();
        vectors++; if (core0 !== 2'b11) begin miscompares++; $display("FAIL rs_e29 got=%b exp=11", core0); end
        tick();
        vectors++; if (rdy0 !== 1'b1 || st0 !== 2'd2 || cnt0 !== 32'd0) begin miscompares++; $display("FAIL rs_e30 got rdy=%b st=%0d cnt=%0d exp rdy=1 st=2 cnt=0", rdy0, st0, cnt0); end
    endtask

    task automatic test_pause();
        for (int k = 0; k < 30; k++) begin
            pause0 = (k >= 10 && k < 17);
            tick();
        end
        pause0 = 1'b0;
        vectors++; if (cnt0 !== 32'd23) begin miscompares++; $display("FAIL pause_cnt got=%0d exp=23", cnt0); end
        pause0 = 1'b1;
        halt0  = 1'b1;
        tick();
        pause0 = 1'b0;
        halt0  = 1'b0;
        vectors++; if (done0 !== 1'b1 || st0 !== 2'd3 || to0 !== 1'b0) begin miscompares++; $display("FAIL pause_halt got done=%b st=%0d to=%b exp done=1 st=3 to=0", done0, st0, to0); end
        vectors++; if (cnt0 !== 32'd23) begin miscompares++; $display("FAIL pause_halt_cnt got=%0d exp=23", cnt0); end
    endtask

    task automatic test_async_reset();
        restart0 = 1'b1;
        tick();
        restart0 = 1'b0;
        repeat (26) tick();
        vectors++; if (core0 !== 2'b01 || st0 !== 2'd1) begin miscompares++; $display("FAIL ar_pre got core=%b st=%0d exp core=01 st=1", core0, st0); end
        rst0_n = 1'b0;
        #1;
        vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL ar_core got=%b exp=00", core0); end
        vectors++; if (st0 !== 2'd0 || rdy0 !== 1'b0) begin miscompares++; $display("FAIL ar_state got st=%0d rdy=%b exp st=0 rdy=0", st0, rdy0); end
        repeat (3) tick();
        vectors++; if (core0 !== 2'b00) begin miscompares++; $display("FAIL ar_held got=%b exp=00", core0); end
        test_release_seq();
    endtask

    task automatic test_limit();
        rst1_n = 1'b1;
        repeat (32) tick();
        vectors++; if (rdy1 !== 1'b1 || cnt1 !== 32'd0) begin miscompares++; $display("FAIL lim_rdy got rdy=%b cnt=%0d exp rdy=1 cnt=0", rdy1, cnt1); end
        repeat (19) tick();
        vectors++; if (cnt1 !== 32'd19 || done1 !== 1'b0) begin miscompares++; $display("FAIL lim_19 got cnt=%0d done=%b exp cnt=19 done=0", cnt1, done1); end
        tick();
        vectors++; if (cnt1 !== 32'd20) begin miscompares++; $display("FAIL lim_cnt got=%0d exp=20", cnt1); end
        vectors++; if (done1 !== 1'b1 || to1 !== 1'b1 || rdy1 !== 1'b0 || st1 !== 2'd3) begin miscompares++; $display("FAIL lim_flags got done=%b to=%b rdy=%b st=%0d exp 1 1 0 3", done1, to1, rdy1, st1); end
        repeat (5) tick();
        vectors++; if (cnt1 !== 32'd20 || to1 !== 1'b1) begin miscompares++; $display("FAIL lim_sticky got cnt=%0d to=%b exp cnt=20 to=1", cnt1, to1); end
        restart1 = 1'b1;
        tick();
        restart1 = 1'b0;
        vectors++; if (to1 !== 1'b0 || cnt1 !== 32'd0) begin miscompares++; $display("FAIL lim_rs got to=%b cnt=%0d exp to=0 cnt=0", to1, cnt1); end
        repeat (30) tick();
        vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL lim_rs_rdy got=%b exp=1", rdy1); end
        repeat (19) tick();
        halt1 = 1'b1;
        tick();
        halt1 = 1'b0;
        vectors++; if (cnt1 !== 32'd19) begin miscompares++; $display("FAIL lim_halt_cnt got=%0d exp=19", cnt1); end
        vectors++; if (done1 !== 1'b1 || to1 !== 1'b0) begin miscompares++; $display("FAIL lim_halt_flags got done=%b to=%b exp done=1 to=0", done1, to1); end
    endtask

    task automatic test_narrow();
        rst2_n = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (k == 27) begin
                vectors++; if (core2 !== 1'b1 || rdy2 !== 1'b0 || st2 !== 2'd1) begin miscompares++; $display("FAIL n1_e27 got core=%b rdy=%b st=%0d exp 1 0 1", core2, rdy2, st2); end
            end
            if (k == 28) begin
                vectors++; if (rdy2 !== 1'b1 || st2 !== 2'd2) begin miscompares++; $display("FAIL n1_e28 got rdy=%b st=%0d exp rdy=1 st=2", rdy2, st2); end
            end
        end
        repeat (15) tick();
        vectors++; if (cnt2 !== 4'd15) begin miscompares++; $display("FAIL sat_reach got=%0d exp=15", cnt2); end
        repeat (5) tick();
        vectors++; if (cnt2 !== 4'd15 || st2 !== 2'd2 || done2 !== 1'b0) begin miscompares++; $display("FAIL sat_hold got cnt=%0d st=%0d done=%b exp 15 2 0", cnt2, st2, done2); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst0_n = 1'b0; halt0 = 1'b0; pause0 = 1'b0; restart0 = 1'b0;
        rst1_n = 1'b0; halt1 = 1'b0; pause1 = 1'b0; restart1 = 1'b0;
        rst2_n = 1'b0; halt2 = 1'b0; pause2 = 1'b0; restart2 = 1'b0;

        test_reset();
        test_release_seq();
        test_halt();
        test_restart();
        test_pause();
        test_async_reset();
        test_limit();
        test_narrow();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
